// File: rtl/sysid_pkg.sv
// Shared types and constants for the sysid boot checker.
// EXPECTED_TS default is also consumed by the software header generator.
package sysid_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ID,
    S_LAT_ID,
    S_RD_TS,
    S_LAT_TS,
    S_CHECK,
    S_DONE
  } state_e;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] SYSID_EXPECTED_TS = 32'd1367819124;

endpackage

// File: rtl/sysid_rd_latency.sv
// Valid shift register marking when read data of an accepted
// Avalon read is present on readdata.
module sysid_rd_latency #(
  parameter int unsigned LATENCY = 0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic accept_i,
  output logic valid_o
);

  localparam int unsigned W = (LATENCY == 0) ? 1 : LATENCY;

  logic [W-1:0] sr_q, sr_d;

  always_comb begin
    sr_d    = sr_q;
    sr_d[0] = accept_i;
    for (int i = 1; i < W; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  // Zero latency: data is valid on the accept cycle itself.
  assign valid_o = (LATENCY == 0) ? accept_i : sr_q[W-1];

endmodule

// File: rtl/sysid_boot_checker.sv
// Boot-time reader/checker of the sysid slave: reads ID and
// timestamp, compares them and publishes sticky status.
module sysid_boot_checker
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = 32'd0,
  parameter logic [31:0] EXPECTED_TS    = SYSID_EXPECTED_TS,
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        av_address,
  output logic        av_read,
  input  logic        av_waitrequest,
  input  logic [31:0] av_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  MAX_R   = 4'(MAX_RETRIES);

  state_e      state_q, state_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic [3:0]  retry_q, retry_d;
  logic        gap_q, gap_d;
  logic [31:0] id_q, id_d;
  logic [31:0] ts_q, ts_d;
  logic        pass_q, pass_d;
  logic        idm_q, idm_d;
  logic        tsm_q, tsm_d;
  logic        tmo_q, tmo_d;
  logic        rd_st;
  logic        is_id;
  logic        accept;
  logic        lat_vld;

  assign rd_st  = (state_q == S_RD_ID) || (state_q == S_RD_TS);
  assign is_id  = (state_q == S_RD_ID);
  assign accept = av_read && !av_waitrequest;

  assign av_read    = rd_st && !gap_q;
  assign av_address =
    ((state_q == S_RD_TS) || (state_q == S_LAT_TS))
      ? SYSID_ADDR_TS : SYSID_ADDR_ID;

  sysid_rd_latency #(
    .LATENCY (READ_LATENCY)
  ) u_lat (
    .clock    (clock),
    .reset_n  (reset_n),
    .accept_i (accept),
    .valid_o  (lat_vld)
  );

  always_comb begin
    state_d  = state_q;
    to_cnt_d = to_cnt_q;
    retry_d  = retry_q;
    gap_d    = 1'b0;
    id_d     = id_q;
    ts_d     = ts_q;
    pass_d   = pass_q;
    idm_d    = idm_q;
    tsm_d    = tsm_q;
    tmo_d    = tmo_q;
    unique case (state_q)
      S_IDLE: begin
        if (AUTO_START || start) begin
          state_d  = S_RD_ID;
          retry_d  = '0;
          to_cnt_d = '0;
        end
      end
      S_RD_ID, S_RD_TS: begin
        if (accept) begin
          to_cnt_d = '0;
          if (READ_LATENCY == 0) begin
            if (is_id) begin
              id_d    = av_readdata;
              state_d = S_RD_TS;
            end else begin
              ts_d    = av_readdata;
              state_d = S_CHECK;
            end
          end else begin
            state_d = is_id ? S_LAT_ID : S_LAT_TS;
          end
        end else if (av_read) begin
          if (to_cnt_q == TO_LAST) begin
            to_cnt_d = '0;
            if (retry_q == MAX_R) begin
              state_d = S_DONE;
              tmo_d   = 1'b1;
              pass_d  = 1'b0;
            end else begin
              retry_d = retry_q + 4'd1;
              gap_d   = 1'b1;
            end
          end else begin
            to_cnt_d = to_cnt_q + 16'd1;
          end
        end
      end
      S_LAT_ID: begin
        if (lat_vld) begin
          id_d    = av_readdata;
          state_d = S_RD_TS;
        end
      end
      S_LAT_TS: begin
        if (lat_vld) begin
          ts_d    = av_readdata;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        idm_d   = (id_q != EXPECTED_ID);
        tsm_d   = (ts_q != EXPECTED_TS);
        pass_d  = (id_q == EXPECTED_ID) &&
                  (ts_q == EXPECTED_TS);
        state_d = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          state_d  = S_RD_ID;
          retry_d  = '0;
          to_cnt_d = '0;
          id_d     = '0;
          ts_d     = '0;
          pass_d   = 1'b0;
          idm_d    = 1'b0;
          tsm_d    = 1'b0;
          tmo_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      to_cnt_q <= '0;
      retry_q  <= '0;
      gap_q    <= 1'b0;
      id_q     <= '0;
      ts_q     <= '0;
      pass_q   <= 1'b0;
      idm_q    <= 1'b0;
      tsm_q    <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
      retry_q  <= retry_d;
      gap_q    <= gap_d;
      id_q     <= id_d;
      ts_q     <= ts_d;
      pass_q   <= pass_d;
      idm_q    <= idm_d;
      tsm_q    <= tsm_d;
      tmo_q    <= tmo_d;
    end
  end

  assign busy        = (state_q != S_IDLE) &&
                       (state_q != S_DONE);
  assign done        = (state_q == S_DONE);
  assign pass        = pass_q;
  assign id_mismatch = idm_q;
  assign ts_mismatch = tsm_q;
  assign timeout     = tmo_q;
  assign id_value    = id_q;
  assign ts_value    = ts_q;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Directed bench for sysid_boot_checker: default, timeout
// and read-latency configurations on separate instances.
module tb_sysid_boot_checker;

  localparam logic [31:0] EXP_TS = 32'd1367819124;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // Instance A: defaults, zero-wait latency-0 slave
  logic        rst_a, start_a, addr_a, rd_a;
  logic [31:0] id_a, rdata_a;
  logic        busy_a, done_a, pass_a, idm_a, tsm_a, tmo_a;
  logic [31:0] idv_a, tsv_a;

  assign rdata_a = addr_a ? EXP_TS : id_a;

  sysid_boot_checker u_a (
    .clock          (clk),
    .reset_n        (rst_a),
    .start          (start_a),
    .av_address     (addr_a),
    .av_read        (rd_a),
    .av_waitrequest (1'b0),
    .av_readdata    (rdata_a),
    .busy           (busy_a),
    .done           (done_a),
    .pass           (pass_a),
    .id_mismatch    (idm_a),
    .ts_mismatch    (tsm_a),
    .timeout        (tmo_a),
    .id_value       (idv_a),
    .ts_value       (tsv_a)
  );

  // Instance B: slave stalls forever
  logic        rst_b, start_b, addr_b, rd_b;
  logic        busy_b, done_b, pass_b, idm_b, tsm_b, tmo_b;
  logic [31:0] idv_b, tsv_b;

  sysid_boot_checker #(
    .TIMEOUT_CYCLES (4),
    .MAX_RETRIES    (2)
  ) u_b (
    .clock          (clk),
    .reset_n        (rst_b),
    .start          (start_b),
    .av_address     (addr_b),
    .av_read        (rd_b),
    .av_waitrequest (1'b1),
    .av_readdata    (32'hFFFF_FFFF),
    .busy           (busy_b),
    .done           (done_b),
    .pass           (pass_b),
    .id_mismatch    (idm_b),
    .ts_mismatch    (tsm_b),
    .timeout        (tmo_b),
    .id_value       (idv_b),
    .ts_value       (tsv_b)
  );

  // Instance C: slave with two-cycle read latency
  logic        rst_c, start_c, addr_c, rd_c;
  logic [31:0] rdata_c;
  logic        busy_c, done_c, pass_c, idm_c, tsm_c, tmo_c;
  logic [31:0] idv_c, tsv_c;
  logic [1:0]  p1 = '0;
  logic [1:0]  p2 = '0;

  always_ff @(posedge clk) begin
    p1 <= {rd_c, addr_c};
    p2 <= p1;
  end

  assign rdata_c = p2[1] ? (p2[0] ? EXP_TS : 32'd0)
                         : 32'hDEAD_BEEF;

  sysid_boot_checker #(
    .READ_LATENCY (2)
  ) u_c (
    .clock          (clk),
    .reset_n        (rst_c),
    .start          (start_c),
    .av_address     (addr_c),
    .av_read        (rd_c),
    .av_waitrequest (1'b0),
    .av_readdata    (rdata_c),
    .busy           (busy_c),
    .done           (done_c),
    .pass           (pass_c),
    .id_mismatch    (idm_c),
    .ts_mismatch    (tsm_c),
    .timeout        (tmo_c),
    .id_value       (idv_c),
    .ts_value       (tsv_c)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [14:0] pat_b;
  logic [7:0]  pat_c;

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    id_a = 32'd0;
    pat_b = '0;
    pat_c = '0;
    repeat (2) tick();

    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_read", rd_a, 0);
    chk("rst_pass", pass_a, 0);
    chk("rst_idv", idv_a, 0);

    // 1: default pass, done 4 edges after release
    rst_a = 1'b1;
    tick();
    chk("t1_rd_id", rd_a, 1);
    chk("t1_addr0", addr_a, 0);
    chk("t1_busy", busy_a, 1);
    tick();
    chk("t1_rd_ts", rd_a, 1);
    chk("t1_addr1", addr_a, 1);
    tick();
    chk("t1_chk_rd", rd_a, 0);
    chk("t1_chk_done", done_a, 0);
    tick();
    chk("t1_done", done_a, 1);
    chk("t1_pass", pass_a, 1);
    chk("t1_busy0", busy_a, 0);
    chk("t1_idv", idv_a, 0);
    chk("t1_tsv", tsv_a, EXP_TS);

    // 2: wrong ID word
    id_a = 32'h0000_0001;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("t2_clr_done", done_a, 0);
    chk("t2_clr_pass", pass_a, 0);
    chk("t2_clr_tsv", tsv_a, 0);
    chk("t2_busy", busy_a, 1);
    repeat (3) tick();
    chk("t2_done", done_a, 1);
    chk("t2_idm", idm_a, 1);
    chk("t2_tsm", tsm_a, 0);
    chk("t2_pass", pass_a, 0);
    chk("t2_idv", idv_a, 1);

    // 5: start while busy and on DONE entry is ignored
    id_a = 32'd0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("t5_idm_clr", idm_a, 0);
    tick();
    chk("t5_in_rdts", addr_a, 1);
    start_a = 1'b1;
    tick();
    chk("t5_ign_rd", rd_a, 0);
    chk("t5_ign_busy", busy_a, 1);
    tick();
    start_a = 1'b0;
    chk("t5_done", done_a, 1);
    chk("t5_pass", pass_a, 1);
    tick();
    chk("t5_stay_done", done_a, 1);
    chk("t5_stay_pass", pass_a, 1);

    // 3: permanent waitrequest, 3 attempts then timeout
    rst_b = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      pat_b = {pat_b[13:0], rd_b};
    end
    chk("t3_pattern", 32'(pat_b),
        32'(15'b111101111011110));
    chk("t3_done", done_b, 1);
    chk("t3_timeout", tmo_b, 1);
    chk("t3_pass", pass_b, 0);
    chk("t3_idv", idv_b, 0);
    chk("t3_busy", busy_b, 0);

    // 4: two-cycle read latency
    rst_c = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      pat_c = {pat_c[6:0], rd_c};
    end
    chk("t4_pattern", 32'(pat_c), 32'(8'b10010000));
    chk("t4_done", done_c, 1);
    chk("t4_pass", pass_c, 1);
    chk("t4_idv", idv_c, 0);
    chk("t4_tsv", tsv_c, EXP_TS);

    // 6: reset during LAT_ID, then auto restart
    start_c = 1'b1;
    tick();
    start_c = 1'b0;
    chk("t6_rd_id", rd_c, 1);
    tick();
    chk("t6_lat_rd", rd_c, 0);
    chk("t6_lat_busy", busy_c, 1);
    rst_c = 1'b0;
    #1;
    chk("t6_async_busy", busy_c, 0);
    chk("t6_async_done", done_c, 0);
    chk("t6_async_rd", rd_c, 0);
    chk("t6_async_pass", pass_c, 0);
    repeat (2) tick();
    rst_c = 1'b1;
    repeat (8) tick();
    chk("t6_done", done_c, 1);
    chk("t6_pass", pass_c, 1);
    chk("t6_tsv", tsv_c, EXP_TS);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
